psum_accumulator: RTL and testbench

- Sequential stage directly downstream of the combinational int8 adder tree.
- Accumulates `Beats` consecutive signed 8-bit partial sums from the tree into one dot-product result, seeded by a per-result bias.
- Applies an arithmetic right shift, saturates to int8, and presents the result on a valid/ready handshake to the next layer stage.

---
 rtl/psum_accumulator_if.sv | 34 +++
 rtl/psum_accumulator.sv | 124 ++++++++++++
 tb/tb_psum_accumulator.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accumulator_if
//  Purpose  : Handshake bundle between the int8 adder tree, the partial-sum
//             accumulator and the next layer stage.
//  Signals  : psum_in / psum_valid_in / psum_ready_out  - upstream beat channel
//             bias_in                                   - per-result bias
//             acc_out / acc_valid_out / acc_ready_in    - downstream result
//             sat_out                                   - result was clamped
//  Modports : master - environment side (drives beats, accepts results)
//             slave  - accumulator side
//  Revision : 1.0 - initial release
// ============================================================================
interface psum_accumulator_if;
  logic [7:0] psum_in;
  logic       psum_valid_in;
  logic       psum_ready_out;
  logic [7:0] bias_in;
  logic [7:0] acc_out;
  logic       acc_valid_out;
  logic       acc_ready_in;
  logic       sat_out;

  modport master (
    output psum_in, psum_valid_in, bias_in, acc_ready_in,
    input  psum_ready_out, acc_out, acc_valid_out, sat_out
  );

  modport slave (
    input  psum_in, psum_valid_in, bias_in, acc_ready_in,
    output psum_ready_out, acc_out, acc_valid_out, sat_out
  );
endinterface
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accumulator
//  Purpose  : Accumulates Beats signed int8 partial sums (seeded by a signed
//             int8 bias taken on the first beat), arithmetic-right-shifts the
//             total by Shift, saturates to int8 and offers the result on a
//             valid/ready handshake.
//  Ports    : clk_in  - single clock, rising edge
//             rst_in  - asynchronous active-high reset
//             bus     - psum_accumulator_if.slave handshake bundle
//  Params   : Beats    - partial sums per result (>= 1)
//             AccWidth - accumulator width (>= 9 + clog2(Beats))
//             Shift    - arithmetic right shift before saturation
//  Revision : 1.0 - initial release
// ============================================================================
module psum_accumulator #(
  parameter int Beats    = 4,
  parameter int AccWidth = 16,
  parameter int Shift    = 0
) (
  input  wire logic           clk_in,
  input  wire logic           rst_in,
  psum_accumulator_if.slave   bus
);

  // A one-beat configuration still needs a 1-bit counter to stay legal.
  localparam int                     c_cnt_w   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [c_cnt_w-1:0]     c_last    = c_cnt_w'(Beats - 1);
  localparam logic signed [AccWidth-1:0] c_sat_max = AccWidth'(127);
  localparam logic signed [AccWidth-1:0] c_sat_min = AccWidth'(-128);

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  state_t                      r_state;
  logic [c_cnt_w-1:0]          r_count;
  logic signed [AccWidth-1:0]  r_acc;
  logic [7:0]                  r_out;
  logic                        r_sat;

  logic                        w_accept;
  logic                        w_first;
  logic signed [AccWidth-1:0]  w_psum_ext;
  logic signed [AccWidth-1:0]  w_bias_ext;
  logic signed [AccWidth-1:0]  w_base;
  logic signed [AccWidth-1:0]  w_total;
  logic signed [AccWidth-1:0]  w_shifted;
  logic [7:0]                  w_clamped;
  logic                        w_clamp_hit;

  // Ready depends only on the state register, so upstream sees no
  // combinational path from our inputs.
  assign w_accept = bus.psum_valid_in && (r_state == ACCUM);

  // Beat 0 seeds from the bias instead of the running accumulator; this also
  // covers Beats == 1 where every beat is both first and last.
  assign w_first    = (r_count == '0);
  assign w_psum_ext = {{(AccWidth-8){bus.psum_in[7]}}, bus.psum_in};
  assign w_bias_ext = {{(AccWidth-8){bus.bias_in[7]}}, bus.bias_in};
  assign w_base     = w_first ? w_bias_ext : r_acc;
  assign w_total    = w_base + w_psum_ext;

  // >>> on a signed operand rounds toward minus infinity.
  assign w_shifted  = w_total >>> Shift;

  always_comb begin
    w_clamped   = w_shifted[7:0];
    w_clamp_hit = 1'b0;
    if (w_shifted > c_sat_max) begin
      w_clamped   = 8'h7f;
      w_clamp_hit = 1'b1;
    end else if (w_shifted < c_sat_min) begin
      w_clamped   = 8'h80;
      w_clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ACCUM;
      r_count <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_count == c_last) begin
              // Final beat: the result register is loaded directly from the
              // clamp, so the result is visible one cycle after this beat.
              r_out   <= w_clamped;
              r_sat   <= w_clamp_hit;
              r_count <= '0;
              r_state <= OUTPUT;
            end else begin
              r_acc   <= w_total;
              r_count <= r_count + c_cnt_w'(1);
            end
          end
        end
        OUTPUT: begin
          // Result and saturation flag persist after hand-off until the
          // next final beat overwrites them.
          if (bus.acc_ready_in) begin
            r_state <= ACCUM;
          end
        end
        default: begin
          r_state <= ACCUM;
        end
      endcase
    end
  end

  assign bus.psum_ready_out = (r_state == ACCUM);
  assign bus.acc_valid_out  = (r_state == OUTPUT);
  assign bus.acc_out        = r_out;
  assign bus.sat_out        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accumulator
//  Purpose  : Self-checking bench for psum_accumulator. Two instances
//             (Shift = 0 and Shift = 2) share one stimulus stream; a
//             queue-based reference model predicts both every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

  localparam int BEATS = 4;
  localparam int SHIFTS [2] = '{0, 2};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] psum = '0;
  logic signed [7:0] bias = '0;
  logic              psum_valid = 1'b0;
  logic              acc_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  psum_accumulator_if ifc0 ();
  psum_accumulator_if ifc2 ();

  assign ifc0.psum_in       = psum;
  assign ifc0.bias_in       = bias;
  assign ifc0.psum_valid_in = psum_valid;
  assign ifc0.acc_ready_in  = acc_ready;
  assign ifc2.psum_in       = psum;
  assign ifc2.bias_in       = bias;
  assign ifc2.psum_valid_in = psum_valid;
  assign ifc2.acc_ready_in  = acc_ready;

  psum_accumulator #(.Beats(BEATS), .AccWidth(16), .Shift(0)) dut0 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifc0)
  );

  psum_accumulator #(.Beats(BEATS), .AccWidth(16), .Shift(2)) dut2 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (ifc2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int floor_shift(input int t, input int sh);
    int d;
    int q;
    d = 1 << sh;
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    return q;
  endfunction

  bit m_pending = 1'b0;
  int m_q[$];
  int m_bias = 0;
  int m_total = 0;
  int m_s = 0;
  int m_out [2] = '{0, 0};
  int m_sat [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 1'b0;
      m_q.delete();
      m_out = '{0, 0};
      m_sat = '{0, 0};
    end else if (m_pending) begin
      if (acc_ready) m_pending = 1'b0;
    end else if (psum_valid) begin
      if (m_q.size() == 0) m_bias = int'(bias);
      m_q.push_back(int'(psum));
      if (m_q.size() == BEATS) begin
        m_total = m_bias;
        foreach (m_q[k]) m_total += m_q[k];
        for (int k = 0; k < 2; k++) begin
          m_s = floor_shift(m_total, SHIFTS[k]);
          m_sat[k] = (m_s > 127 || m_s < -128) ? 1 : 0;
          m_out[k] = (m_s > 127) ? 127 : ((m_s < -128) ? -128 : m_s);
        end
        m_pending = 1'b1;
        m_q.delete();
      end
    end
  end

  // Every-cycle comparison against the model, sampled away from both edges.
  always @(negedge clk) begin
    #1;
    check("m_ready0", int'(ifc0.psum_ready_out), int'(!m_pending));
    check("m_valid0", int'(ifc0.acc_valid_out),  int'(m_pending));
    check("m_acc0",   int'($signed(ifc0.acc_out)), m_out[0]);
    check("m_sat0",   int'(ifc0.sat_out), m_sat[0]);
    check("m_ready2", int'(ifc2.psum_ready_out), int'(!m_pending));
    check("m_valid2", int'(ifc2.acc_valid_out),  int'(m_pending));
    check("m_acc2",   int'($signed(ifc2.acc_out)), m_out[1]);
    check("m_sat2",   int'(ifc2.sat_out), m_sat[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input int b, input int p);
    int n = 0;
    bias = 8'(b);
    psum = 8'(p);
    psum_valid = 1'b1;
    while (!ifc0.psum_ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: ready stayed %0d, expected 1", ifc0.psum_ready_out);
    end
    @(posedge clk);
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic send4(input int b, input int p0, input int p1, input int p2, input int p3);
    send_beat(b, p0);
    send_beat(b, p1);
    send_beat(b, p2);
    send_beat(b, p3);
  endtask

  // Called at the negedge right after the final beat was accepted.
  task automatic take_result(input string name, input int e0, input int s0,
                             input int e2, input int s2);
    check({name, "_valid"}, int'(ifc0.acc_valid_out), 1);
    check({name, "_acc0"},  int'($signed(ifc0.acc_out)), e0);
    check({name, "_sat0"},  int'(ifc0.sat_out), s0);
    check({name, "_acc2"},  int'($signed(ifc2.acc_out)), e2);
    check({name, "_sat2"},  int'(ifc2.sat_out), s2);
    check({name, "_model0"}, m_out[0], e0);
    check({name, "_model2"}, m_out[1], e2);
    acc_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  int bub_v [7] = '{1, 0, 0, 1, 1, 0, 1};
  int bub_p [7] = '{10, 77, 77, 20, 30, 77, 40};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_acc",   int'(ifc0.acc_out), 0);
    check("rst_sat",   int'(ifc0.sat_out), 0);
    check("rst_valid", int'(ifc0.acc_valid_out), 0);
    check("rst_ready", int'(ifc0.psum_ready_out), 1);
    rst = 1'b0;
    @(negedge clk);

    // Basic, saturation and floor-rounding results.
    send4(1, 10, 20, 30, 40);        take_result("basic", 101, 0, 25, 0);
    send4(0, 100, 100, 100, 100);    take_result("pos_sat", 127, 1, 100, 0);
    send4(0, -100, -100, -100, -100); take_result("neg_sat", -128, 1, -100, 0);
    send_beat(-128, -128);
    send_beat(0, 0);
    send_beat(0, 0);
    send_beat(0, 0);                 take_result("min_edge", -128, 1, -64, 0);
    send4(-1, -10, -20, -30, -40);   take_result("floor", -101, 0, -26, 0);
    send4(127, 127, 127, 127, 127);  take_result("both_sat", 127, 1, 127, 1);

    // Backpressure: result held, pending beat not consumed.
    send4(2, 1, 2, 3, 4);
    psum = 8'sd50;
    bias = 8'sd7;
    psum_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", int'(ifc0.psum_ready_out), 0);
      check("bp_hold",  int'($signed(ifc0.acc_out)), 12);
    end
    take_result("bp", 12, 0, 3, 0);
    check("bp_resume", int'(ifc0.psum_ready_out), 1);
    send_beat(7, 50);
    send_beat(0, 5);
    send_beat(0, 5);
    send_beat(0, 5);
    take_result("bp_next", 72, 0, 18, 0);

    // Bubbles between beats; bias changes after beat 0 are ignored.
    for (int i = 0; i < 7; i++) begin
      psum_valid = (bub_v[i] != 0);
      psum = 8'(bub_p[i]);
      bias = (i == 0) ? 8'sd1 : 8'sd99;
      @(negedge clk);
    end
    psum_valid = 1'b0;
    take_result("bubble", 101, 0, 25, 0);

    // Reset after two beats discards the partial result.
    send_beat(5, 60);
    send_beat(5, 60);
    rst = 1'b1;
    psum = 8'sd33;
    psum_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_acc0",  int'(ifc0.acc_out), 0);
    check("mid_rst_acc2",  int'(ifc2.acc_out), 0);
    check("mid_rst_valid", int'(ifc0.acc_valid_out), 0);
    check("mid_rst_sat",   int'(ifc0.sat_out), 0);
    @(negedge clk);
    rst = 1'b0;
    psum_valid = 1'b0;
    @(negedge clk);
    send4(0, 1, 2, 3, 4);
    take_result("after_rst", 10, 0, 2, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
